// File: rtl/decode_stage_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decode_stage_param                                         |
// | Description : Parametrised decode stage between ifetch and exec.         |
// |               Skid FIFO of SKID_DEPTH entries, NUM_BYPASS-source bypass  |
// |               network (source 0 = youngest = highest priority),          |
// |               load-use hazard stall, x0 forcing, separate rs2 read path  |
// |               and a 2-bit exception cause code.                          |
// | Config      : define DECODE_PERF_EN to add perf_stall_cnt and            |
// |               perf_bubble_cnt (wrapping, cleared by rst only).           |
// | Ports       : clk/rst (sync, active-high), flush                          |
// |               in_*   : fetch valid/ready handshake + payload             |
// |               rf_rd* : async regfile select (comb from FIFO head) / data  |
// |               byp_*  : per-source valid, data_ok, dest reg, data         |
// |               out_*  : registered decoded bundle, valid/ready handshake  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module decode_stage_param #(
    parameter int XLEN       = 32,
    parameter int ALEN       = 32,
    parameter int NUM_BYPASS = 2,
    parameter int SKID_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
`ifdef DECODE_PERF_EN
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_bubble_cnt,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_fault,
    input  logic [31:0]                  in_instr,
    input  logic [ALEN-1:0]              in_addr,
    input  logic [ALEN-1:0]              in_next_addr,
    output logic [4:0]                   rf_rd1_sel,
    input  logic [XLEN-1:0]              rf_rd1_data,
    output logic [4:0]                   rf_rd2_sel,
    input  logic [XLEN-1:0]              rf_rd2_data,
    input  logic [NUM_BYPASS-1:0]        byp_valid,
    input  logic [NUM_BYPASS-1:0]        byp_data_ok,
    input  logic [5*NUM_BYPASS-1:0]      byp_reg,
    input  logic [XLEN*NUM_BYPASS-1:0]   byp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_exc_cause,
    output logic [4:0]                   out_opcode,
    output logic [4:0]                   out_rd,
    output logic [2:0]                   out_funct3,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [6:0]                   out_funct7,
    output logic [11:0]                  out_i_imm,
    output logic [19:0]                  out_u_imm,
    output logic [19:0]                  out_j_imm,
    output logic                         out_is_jump,
    output logic                         out_is_reg_write,
    output logic [XLEN-1:0]              out_rs1_data,
    output logic [XLEN-1:0]              out_rs2_data,
    output logic [ALEN-1:0]              out_addr,
    output logic [ALEN-1:0]              out_next_addr
);

    localparam int c_PTR_W = $clog2(SKID_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 1 + 32 + 2 * ALEN;

    // 5-bit major opcodes (instr[6:2])
    localparam logic [4:0] c_OP_STORE  = 5'b01000;
    localparam logic [4:0] c_OP_BRANCH = 5'b11000;
    localparam logic [4:0] c_OP_SYSTEM = 5'b11100;

    logic [c_ENT_W-1:0] r_mem [SKID_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_in_ready;
    logic               r_out_valid;

    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic               w_hazard;
    logic [c_CNT_W-1:0] w_count_next;

    logic               w_fault;
    logic [31:0]        w_instr;
    logic [ALEN-1:0]    w_addr;
    logic [ALEN-1:0]    w_next_addr;
    logic [4:0]         w_opcode;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic [4:0]         w_rd;
    logic               w_legal;
    logic [1:0]         w_cause;
    logic               w_reg_write;
    logic [XLEN:0]      w_op1;
    logic [XLEN:0]      w_op2;

    // Returns {data_ok, data}. Scanning from the oldest source down to 0
    // lets the youngest matching source overwrite the others.
    function automatic logic [XLEN:0] f_resolve(
        input logic [4:0]                 rs,
        input logic [XLEN-1:0]            rf_data,
        input logic [NUM_BYPASS-1:0]      bv,
        input logic [NUM_BYPASS-1:0]      bok,
        input logic [5*NUM_BYPASS-1:0]    breg,
        input logic [XLEN*NUM_BYPASS-1:0] bdata
    );
        logic            ok;
        logic [XLEN-1:0] d;
        ok = 1'b1;
        d  = rf_data;
        for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
            if (bv[i] && (breg[5*i +: 5] == rs)) begin
                ok = bok[i];
                d  = bdata[XLEN*i +: XLEN];
            end
        end
        // x0 never stalls and never picks up a bypassed value
        if (rs == 5'd0) begin
            ok = 1'b1;
            d  = '0;
        end
        return {ok, d};
    endfunction

    assign {w_fault, w_instr, w_addr, w_next_addr} = r_mem[r_rptr];

    assign w_opcode   = w_instr[6:2];
    assign w_rd       = w_instr[11:7];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign rf_rd1_sel = w_rs1;
    assign rf_rd2_sel = w_rs2;

    assign w_op1 = f_resolve(w_rs1, rf_rd1_data, byp_valid, byp_data_ok, byp_reg, byp_data);
    assign w_op2 = f_resolve(w_rs2, rf_rd2_data, byp_valid, byp_data_ok, byp_reg, byp_data);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_cause = 2'd0;
        if (w_fault) begin
            w_cause = 2'd1;
        end else if ((w_instr[1:0] != 2'b11) || !w_legal) begin
            w_cause = 2'd2;
        end
    end

    assign w_reg_write = (w_cause == 2'd0) && (w_rd != 5'd0) &&
                         (w_opcode != c_OP_STORE) && (w_opcode != c_OP_BRANCH) &&
                         (w_opcode != c_OP_SYSTEM);

    assign w_head_valid = (r_count != '0);
    assign w_hazard     = !w_op1[XLEN] || !w_op2[XLEN];
    assign w_pop        = w_head_valid && !w_hazard && (!r_out_valid || out_ready);
    // r_in_ready is already 0 when full, so a push never collides with a full FIFO
    assign w_push       = in_valid && r_in_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_W'(1);
            2'b01:   w_count_next = r_count - c_CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_mem[r_wptr] <= {in_fault, in_instr, in_addr, in_next_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != c_CNT_W'(SKID_DEPTH));
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_exc_cause    <= '0;
            out_opcode       <= '0;
            out_rd           <= '0;
            out_funct3       <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_funct7       <= '0;
            out_i_imm        <= '0;
            out_u_imm        <= '0;
            out_j_imm        <= '0;
            out_is_jump      <= 1'b0;
            out_is_reg_write <= 1'b0;
            out_rs1_data     <= '0;
            out_rs2_data     <= '0;
            out_addr         <= '0;
            out_next_addr    <= '0;
        end else if (w_pop) begin
            out_exc_cause    <= w_cause;
            out_opcode       <= w_opcode;
            out_rd           <= w_rd;
            out_funct3       <= w_instr[14:12];
            out_rs1          <= w_rs1;
            out_rs2          <= w_rs2;
            out_funct7       <= w_instr[31:25];
            out_i_imm        <= w_instr[31:20];
            out_u_imm        <= w_instr[31:12];
            out_j_imm        <= {w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21]};
            out_is_jump      <= (w_instr[6:5] == 2'b11);
            out_is_reg_write <= w_reg_write;
            out_rs1_data     <= w_op1[XLEN-1:0];
            out_rs2_data     <= w_op2[XLEN-1:0];
            out_addr         <= w_addr;
            out_next_addr    <= w_next_addr;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (w_head_valid && w_hazard) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (out_ready && !r_out_valid) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decode_stage_param                                      |
// | Description : Scoreboard bench for decode_stage_param: expected bundles  |
// |               are queued at send time and compared as they leave exec.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_decode_stage_param;

    localparam int XLEN = 32;
    localparam int ALEN = 32;
    localparam int NB   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_fault = 1'b0;
    logic [31:0]      in_instr = '0;
    logic [ALEN-1:0]  in_addr = '0;
    logic [ALEN-1:0]  in_next_addr = '0;
    logic [4:0]       rf_rd1_sel, rf_rd2_sel;
    logic [XLEN-1:0]  rf_rd1_data, rf_rd2_data;
    logic [NB-1:0]    byp_valid = '0;
    logic [NB-1:0]    byp_data_ok = '1;
    logic [5*NB-1:0]  byp_reg = '0;
    logic [XLEN*NB-1:0] byp_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:0]       out_exc_cause;
    logic [4:0]       out_opcode, out_rd, out_rs1, out_rs2;
    logic [2:0]       out_funct3;
    logic [6:0]       out_funct7;
    logic [11:0]      out_i_imm;
    logic [19:0]      out_u_imm, out_j_imm;
    logic             out_is_jump, out_is_reg_write;
    logic [XLEN-1:0]  out_rs1_data, out_rs2_data;
    logic [ALEN-1:0]  out_addr, out_next_addr;
`ifdef DECODE_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_bubble_cnt;
`endif

    logic [XLEN-1:0]  rf_mem [32];
    assign rf_rd1_data = rf_mem[rf_rd1_sel];
    assign rf_rd2_data = rf_mem[rf_rd2_sel];

    decode_stage_param #(.XLEN(XLEN), .ALEN(ALEN), .NUM_BYPASS(NB), .SKID_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
`ifdef DECODE_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_fault(in_fault),
        .in_instr(in_instr), .in_addr(in_addr), .in_next_addr(in_next_addr),
        .rf_rd1_sel(rf_rd1_sel), .rf_rd1_data(rf_rd1_data),
        .rf_rd2_sel(rf_rd2_sel), .rf_rd2_data(rf_rd2_data),
        .byp_valid(byp_valid), .byp_data_ok(byp_data_ok), .byp_reg(byp_reg), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_exc_cause(out_exc_cause),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_i_imm(out_i_imm), .out_u_imm(out_u_imm), .out_j_imm(out_j_imm),
        .out_is_jump(out_is_jump), .out_is_reg_write(out_is_reg_write),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_addr(out_addr), .out_next_addr(out_next_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] i_imm;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [1:0]  cause;
        logic        wr;
        logic        jmp;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    // Reference operand: x0 is zero, otherwise first (lowest-index) matching bypass, else regfile
    function automatic logic [31:0] model_operand(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < NB; i++) begin
            if (byp_valid[i] && byp_reg[5*i +: 5] == rs) return byp_data[XLEN*i +: XLEN];
        end
        return rf_mem[rs];
    endfunction

    function automatic logic [1:0] model_cause(input logic fault, input logic [31:0] instr);
        logic legal;
        if (fault) return 2'd1;
        case (instr[6:0])
            7'h03, 7'h0F, 7'h13, 7'h17, 7'h33, 7'h37, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h73: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal ? 2'd0 : 2'd2;
    endfunction

    task automatic send(input logic fault, input logic [31:0] instr, input logic [31:0] addr);
        exp_t e;
        int   n;
        in_valid     = 1'b1;
        in_fault     = fault;
        in_instr     = instr;
        in_addr      = addr;
        in_next_addr = addr + 32'd4;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", in_ready, 1);
        end else begin
            e.i_imm    = instr[31:20];
            e.rd       = instr[11:7];
            e.rs1_data = model_operand(instr[19:15]);
            e.rs2_data = model_operand(instr[24:20]);
            e.cause    = model_cause(fault, instr);
            e.jmp      = (instr[6:5] == 2'b11);
            e.wr       = (e.cause == 2'd0) && (instr[11:7] != 5'd0) &&
                         !(instr[6:0] inside {7'h23, 7'h63, 7'h73});
            e.addr     = addr;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    // Bundle consumer: out_valid && out_ready seen here is taken at the next edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_bundle", out_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("i_imm", out_i_imm, e.i_imm);
                check_eq("rd", out_rd, e.rd);
                check_eq("rs1_data", out_rs1_data, e.rs1_data);
                check_eq("rs2_data", out_rs2_data, e.rs2_data);
                check_eq("exc_cause", out_exc_cause, e.cause);
                check_eq("is_reg_write", out_is_reg_write, e.wr);
                check_eq("is_jump", out_is_jump, e.jmp);
                check_eq("addr", out_addr, e.addr);
                check_eq("next_addr", out_next_addr, e.addr + 32'd4);
            end
        end
    end

    initial begin
        logic [31:0] stall0;
        stall0 = '0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'h0101_0101 * i;
        rf_mem[5] = 32'h1111;
        rf_mem[7] = 32'h77;

        // Reset
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_fields", |{out_exc_cause, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
                                 out_funct7, out_i_imm, out_u_imm, out_j_imm, out_is_jump,
                                 out_is_reg_write, out_rs1_data, out_rs2_data, out_addr,
                                 out_next_addr}, 0);
`ifdef DECODE_PERF_EN
        check_eq("rst_perf_stall", perf_stall_cnt, 0);
`endif

        // Streaming: 4 back-to-back ADDIs, one bundle per cycle after 1-cycle latency
        send(1'b0, enc_addi(5'd1, 5'd0, 12'd1), 32'h100);
        check_eq("stream_lat0", out_valid, 0);
        send(1'b0, enc_addi(5'd2, 5'd0, 12'd2), 32'h104);
        check_eq("stream_v1", out_valid, 1);
        send(1'b0, enc_addi(5'd3, 5'd0, 12'h7FF), 32'h108);
        check_eq("stream_v2", out_valid, 1);
        send(1'b0, enc_addi(5'd4, 5'd0, 12'hFFC), 32'h10C);
        check_eq("stream_v3", out_valid, 1);
        @(posedge clk); #1;
        check_eq("stream_v4", out_valid, 1);
        @(posedge clk); #1;
        check_eq("stream_end", out_valid, 0);
        drain();

        // Bypass priority: both sources match x5, source 0 wins; then source 1 alone
        byp_valid = 2'b11;
        byp_reg   = {5'd5, 5'd5};
        byp_data  = {32'hBBBB, 32'hAAAA};
        send(1'b0, enc_add(5'd9, 5'd5, 5'd6), 32'h200);
        drain();
        byp_valid = 2'b10;
        send(1'b0, enc_add(5'd9, 5'd5, 5'd6), 32'h204);
        drain();

        // rs2 from port 2, rs1=x0 ignores a bypass targeting x0
        byp_valid = 2'b01;
        byp_reg   = {5'd0, 5'd0};
        byp_data  = {32'h0, 32'hFF};
        send(1'b0, enc_add(5'd10, 5'd0, 5'd7), 32'h300);
        drain();

        // Load-use: source 0 targets x3 with data pending for 2 cycles
`ifdef DECODE_PERF_EN
        stall0 = perf_stall_cnt;
`endif
        byp_valid   = 2'b01;
        byp_reg     = {5'd0, 5'd3};
        byp_data    = {32'h0, 32'h3333};
        byp_data_ok = 2'b10;
        send(1'b0, enc_add(5'd11, 5'd3, 5'd0), 32'h400);
        send(1'b0, enc_addi(5'd12, 5'd0, 12'd5), 32'h404);
        check_eq("lu_in_ready_full", in_ready, 0);
        check_eq("lu_no_bundle0", out_valid, 0);
        @(posedge clk); #1;
        check_eq("lu_no_bundle1", out_valid, 0);
        byp_data_ok = 2'b11;
        @(posedge clk); #1;
        check_eq("lu_release", out_valid, 1);
        drain();
`ifdef DECODE_PERF_EN
        check_eq("perf_stall_delta", perf_stall_cnt - stall0, 2);
`endif
        byp_valid = 2'b00;

        // Exceptions
        send(1'b1, enc_addi(5'd1, 5'd0, 12'd1), 32'h500);
        send(1'b0, 32'h0000_0001, 32'h504);
        send(1'b0, {25'd0, 7'b1111111}, 32'h508);
        drain();

        // Flush with a held bundle and two FIFO entries, plus a same-cycle push
        out_ready = 1'b0;
        send(1'b0, enc_addi(5'd1, 5'd0, 12'd11), 32'h600);
        send(1'b0, enc_addi(5'd2, 5'd0, 12'd12), 32'h604);
        send(1'b0, enc_addi(5'd3, 5'd0, 12'd13), 32'h608);
        check_eq("fl_pre_valid", out_valid, 1);
        check_eq("fl_pre_full", in_ready, 0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = enc_addi(5'd4, 5'd0, 12'd14);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_eq("fl_out_valid", out_valid, 0);
        check_eq("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("fl_quiet", out_valid, 0);

        // Flow resumes after flush
        send(1'b0, enc_addi(5'd5, 5'd0, 12'd21), 32'h700);
        drain();
        check_eq("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
